// File: rtl/riscv_mem_arbiter.sv
// Time-multiplexes instruction fetch and data access of a single-cycle RISC-V core
// onto one shared memory port: FETCH -> DATA -> EXEC, with a per-access wait timeout.
module riscv_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] core_pc,
  output logic [DATA_W-1:0] core_instr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              core_mem_read,
  input  logic              core_mem_write,
  output logic              core_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              bus_err,
  output logic [31:0]       retire_count
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]     TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] NOP     = DATA_W'(32'h0000_0013);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DATA  = 2'd1,
    S_EXEC  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       retire_q, retire_d;

  logic              req, we, stall;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              data_acc;
  logic              load_only;
  logic              timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      instr_q  <= NOP;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      retire_q <= retire_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    retire_d    = retire_q;
    req         = 1'b0;
    we          = 1'b0;
    stall       = 1'b1;
    addr        = '0;
    wdata       = '0;
    data_acc    = core_mem_read | core_mem_write;
    // Write wins when both are decoded, so only a pure load updates core_rdata.
    load_only   = core_mem_read & ~core_mem_write;
    timeout_hit = 1'b0;

    case (state_q)
      S_FETCH: begin
        req         = 1'b1;
        addr        = core_pc;
        timeout_hit = ~mem_ready && (cnt_q == TO_LAST);
        if (mem_ready) begin
          instr_d = mem_rdata;
          cnt_d   = '0;
          state_d = S_DATA;
        end else if (timeout_hit) begin
          instr_d = NOP;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (!data_acc) begin
          cnt_d   = '0;
          state_d = S_EXEC;
        end else begin
          req         = 1'b1;
          we          = core_mem_write;
          addr        = core_addr;
          wdata       = core_wdata;
          timeout_hit = ~mem_ready && (cnt_q == TO_LAST);
          if (mem_ready) begin
            if (load_only) rdata_d = mem_rdata;
            cnt_d   = '0;
            state_d = S_EXEC;
          end else if (timeout_hit) begin
            // Abandoned load returns zero; abandoned store is simply dropped.
            if (load_only) rdata_d = '0;
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_EXEC;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_EXEC: begin
        stall    = 1'b0;
        retire_d = retire_q + 32'd1;
        cnt_d    = '0;
        state_d  = S_FETCH;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_FETCH;
      end
    endcase
  end

  // Request qualifiers are gated by rst so a reset mid-access drops the bus immediately.
  assign mem_req      = req & ~rst;
  assign mem_we       = we & ~rst;
  assign mem_addr     = rst ? '0 : addr;
  assign mem_wdata    = rst ? '0 : wdata;
  assign core_stall   = stall;
  assign core_instr   = instr_q;
  assign core_rdata   = rdata_q;
  assign bus_err      = err_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed, table-driven bench for riscv_mem_arbiter with a small phase model and memory responder.
module tb_riscv_mem_arbiter;

  localparam int TO = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] core_pc, core_instr, core_addr, core_wdata, core_rdata;
  logic        core_mem_read, core_mem_write, core_stall;
  logic        mem_req, mem_we, mem_ready, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, retire_count;

  int checks = 0;
  int errors = 0;
  int exp_retire = 0;

  riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .core_pc(core_pc), .core_instr(core_instr),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_mem_read(core_mem_read), .core_mem_write(core_mem_write),
    .core_stall(core_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_err(bus_err), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          fwait;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dwait;
    int          exp_cycles;
    logic [31:0] exp_instr;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Runs one instruction from its first FETCH cycle through EXEC, checking the bus every cycle.
  task automatic run_vec(input vec_t v, input int idx);
    int ph, w, cyc;
    logic        e_req, e_we, e_stall;
    logic [31:0] e_addr, e_wdata;
    ph = 0; w = 0; cyc = 0;
    core_pc = v.pc; core_addr = v.addr; core_wdata = v.wdata;
    core_mem_read = v.rd; core_mem_write = v.wr;
    while (ph != 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      case (ph)
        0: begin mem_ready = (w == v.fwait); mem_rdata = v.instr; end
        1: begin mem_ready = (w == v.dwait); mem_rdata = v.rdata; end
        default: begin mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF; end
      endcase
      e_req = 1'b0; e_we = 1'b0; e_stall = 1'b1; e_addr = '0; e_wdata = '0;
      if (ph == 0) begin
        e_req = 1'b1; e_addr = v.pc;
      end else if (ph == 1) begin
        if (v.rd || v.wr) begin
          e_req = 1'b1; e_we = v.wr; e_addr = v.addr; e_wdata = v.wdata;
        end
      end else begin
        e_stall = 1'b0;
      end
      #1;
      chk($sformatf("v%0d_c%0d_req_we_stall", idx, cyc),
          {61'd0, mem_req, mem_we, core_stall}, {61'd0, e_req, e_we, e_stall});
      chk($sformatf("v%0d_c%0d_addr", idx, cyc), {32'd0, mem_addr}, {32'd0, e_addr});
      if (e_we) chk($sformatf("v%0d_c%0d_wdata", idx, cyc), {32'd0, mem_wdata}, {32'd0, e_wdata});
      if (ph == 2) begin
        chk($sformatf("v%0d_instr", idx), {32'd0, core_instr}, {32'd0, v.exp_instr});
        chk($sformatf("v%0d_rdata", idx), {32'd0, core_rdata}, {32'd0, v.exp_rdata});
        chk($sformatf("v%0d_bus_err", idx), {63'd0, bus_err}, {63'd0, v.exp_err});
        chk($sformatf("v%0d_retire", idx), {32'd0, retire_count}, 64'(exp_retire));
        exp_retire++;
        ph = 3;
      end else if (ph == 1 && !(v.rd || v.wr)) begin
        ph = 2;
      end else if (mem_ready || (w + 1 == TO)) begin
        ph = ph + 1; w = 0;
      end else begin
        w++;
      end
    end
    if (ph != 3) chk($sformatf("v%0d_timeout_bound", idx), 64'(ph), 64'd3);
    chk($sformatf("v%0d_period", idx), 64'(cyc), 64'(v.exp_cycles));
  endtask

  initial begin
    //           pc        instr          fw rd  wr  addr   wdata          rdata          dw cyc exp_instr      exp_rdata      err
    vecs[0] = '{32'h00, 32'h0010_0093, 0, 0, 0, 32'h00, 32'h0,         32'h0,         0, 3, 32'h0010_0093, 32'h0,         0};
    vecs[1] = '{32'h04, 32'h0400_2283, 0, 1, 0, 32'h40, 32'h0,         32'hDEAD_BEEF, 2, 5, 32'h0400_2283, 32'hDEAD_BEEF, 0};
    vecs[2] = '{32'h08, 32'h0810_2023, 1, 0, 1, 32'h80, 32'h1234_5678, 32'hCAFE_F00D, 1, 5, 32'h0810_2023, 32'hDEAD_BEEF, 0};
    vecs[3] = '{32'h0C, 32'h1111_1111, 0, 1, 1, 32'h90, 32'hA5A5_A5A5, 32'h5555_5555, 0, 3, 32'h1111_1111, 32'hDEAD_BEEF, 0};
    vecs[4] = '{32'h10, 32'h0440_2303, 2, 1, 0, 32'h44, 32'h0,         32'h0BAD_F00D, 0, 5, 32'h0440_2303, 32'h0BAD_F00D, 0};
    vecs[5] = '{32'h14, 32'h0020_8133, 3, 0, 0, 32'h00, 32'h0,         32'h0,         0, 6, 32'h0020_8133, 32'h0BAD_F00D, 0};
    vecs[6] = '{32'h18, 32'h0480_2383, 0, 1, 0, 32'h48, 32'h0,         32'h600D_D00D, 3, 6, 32'h0480_2383, 32'h600D_D00D, 0};
    vecs[7] = '{32'h1C, 32'hFFFF_FFFF, 99, 0, 0, 32'h00, 32'h0,        32'h0,         0, 6, NOP,           32'h600D_D00D, 1};
    vecs[8] = '{32'h20, 32'h04C0_2403, 0, 1, 0, 32'h4C, 32'h0,         32'h7777_7777, 99, 6, 32'h04C0_2403, 32'h0,        1};
    vecs[9] = '{32'h24, 32'h0890_2223, 0, 0, 1, 32'h88, 32'hCCCC_0001, 32'h0,         99, 6, 32'h0890_2223, 32'h0,        1};

    rst = 1'b1; core_pc = 32'h0; core_addr = '0; core_wdata = '0;
    core_mem_read = 1'b0; core_mem_write = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst_stall", {63'd0, core_stall}, 64'd1);
    chk("rst_instr", {32'd0, core_instr}, {32'd0, NOP});
    chk("rst_rdata", {32'd0, core_rdata}, 64'd0);
    chk("rst_bus_err", {63'd0, bus_err}, 64'd0);
    chk("rst_retire", {32'd0, retire_count}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset in the middle of a stalled DATA read.
    @(negedge clk);
    core_pc = 32'h28; core_addr = 32'h50; core_mem_read = 1'b1; core_mem_write = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h0500_2503;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = 32'h9999_9999;
    #1;
    chk("mid_data_req", {63'd0, mem_req}, 64'd1);
    chk("mid_data_addr", {32'd0, mem_addr}, 64'h50);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", {63'd0, mem_req}, 64'd0);
    chk("mid_rst_stall", {63'd0, core_stall}, 64'd1);
    chk("mid_rst_instr", {32'd0, core_instr}, {32'd0, NOP});
    chk("mid_rst_bus_err", {63'd0, bus_err}, 64'd0);
    chk("mid_rst_retire", {32'd0, retire_count}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_retire = 0;
    run_vec('{32'h100, 32'h0010_0093, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 3, 32'h0010_0093, 32'h0, 0}, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Sequences the single-cycle RISC-V core against one shared unified memory port, so instruction fetch and data access are time-multiplexed.
- Per instruction: fetches the instruction into a holding register, then performs the data access if the instruction needs one, then releases the core stall for exactly one execute cycle.
- Sits between the core's fetch/data interface (pc, instr, alu_result, write_data, read_data, mem_read, mem_write, stall_in) and the external memory.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, data/instruction width.
- TIMEOUT, 255, maximum cycles mem_req may stay high without mem_ready before the access is abandoned (TIMEOUT >= 1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- core_pc  in  ADDR_W  fetch address from core.
- core_instr  out  DATA_W  registered instruction to core.
- core_addr  in  ADDR_W  data address (core alu_result).
- core_wdata  in  DATA_W  store data (core write_data).
- core_rdata  out  DATA_W  registered load data to core.
- core_mem_read  in  1  load request, decoded by core from core_instr.
- core_mem_write  in  1  store request, decoded by core from core_instr.
- core_stall  out  1  hold core; drives core stall_in.
- mem_req  out  1  memory access request.
- mem_we  out  1  write enable, valid with mem_req.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1.
- mem_ready  in  1  access complete; may be high in the same cycle mem_req rises.
- bus_err  out  1  sticky timeout flag.
- retire_count  out  32  executed-instruction counter.

Behaviour:
- Reset values (async, immediate):
  - state=FETCH, core_instr=32'h00000013 (NOP), core_rdata=0, core_stall=1.
  - mem_req=0 and mem_we=0 (mem_req/mem_we are gated by !rst).
  - bus_err=0, retire_count=0, timeout counter=0.
- FETCH state:
  - mem_req=1, mem_we=0, mem_addr=core_pc.
  - On a mem_ready edge: core_instr<=mem_rdata, go to DATA.
- DATA state (core_instr is stable, so core_mem_read/core_mem_write are valid):
  - If core_mem_read or core_mem_write: mem_req=1, mem_we=core_mem_write, mem_addr=core_addr, mem_wdata=core_wdata.
  - On mem_ready with a read: core_rdata<=mem_rdata. In either case, go to EXEC.
  - If neither read nor write: mem_req=0, go to EXEC at the next edge.
  - If both read and write are high, write wins (mem_we=1) and core_rdata is unchanged.
- EXEC state:
  - core_stall=0 for exactly one cycle; mem_req=0.
  - retire_count+=1 (wraps at 2^32-1 -> 0).
  - Go to FETCH.
- core_stall=1 in FETCH and DATA.
- Core contract: while core_stall=1 the core suppresses PC update and register-file writes; its architectural state commits only at the EXEC edge.
- Request hold rule: while mem_req=1 and mem_ready=0, mem_addr, mem_we and mem_wdata stay stable.
- mem_addr/mem_wdata/mem_we are don't-care when mem_req=0; drive them to 0.
- Throughput with zero-wait memory: 3 cycles per instruction (FETCH, DATA, EXEC), with or without a data access. Each wait cycle adds 1.
- Timeout:
  - The counter increments each cycle mem_req=1 and mem_ready=0, and clears on state change.
  - When the counter reaches TIMEOUT, the access is abandoned: bus_err<=1 and the state advances as if ready.
  - Substitute data on abandon: FETCH loads core_instr<=NOP; a DATA read loads core_rdata<=0; a DATA write is dropped.
  - If mem_ready and the timeout occur in the same cycle, mem_ready wins and bus_err is not set.
- bus_err clears only on rst.
- Reset mid-access: mem_req drops asynchronously, the partial access is discarded, and the first request after reset release is a FETCH of core_pc.
- No alignment checking: addresses are forwarded unchanged.

Test Plan:
- Zero-wait memory, ALU op (addi, no data access) -> mem_req sequence 1,0,0; core_stall 1,1,0; retire_count=1 after 3 cycles; instruction period 3 cycles.
- Load with mem_ready delayed 2 cycles in DATA, mem_rdata=32'hDEADBEEF at core_addr=0x40 -> mem_addr=0x40 held for 3 cycles, core_rdata=32'hDEADBEEF in EXEC, core_stall low 1 cycle.
- Store core_addr=0x80, core_wdata=0x12345678 -> single write beat with mem_we=1 and stable address/data until ready; core_rdata unchanged.
- mem_ready never asserted in FETCH with TIMEOUT=4 -> bus_err=1 after 4 wait cycles; core_instr=32'h00000013; the core still gets one EXEC cycle; bus_err stays 1 until rst.
- mem_ready and timeout in the same cycle -> data accepted, bus_err=0.
- rst asserted mid-DATA wait -> mem_req=0 the same cycle; after release, the first access is a FETCH of core_pc; retire_count=0.
